// File: rtl/write_seq_checker.sv
// write_seq_checker
//   Multi-channel monitor for the write handshake sequence:
//     do_wr (data captured) -> ready held MIN_READY..MAX_READY cycles
//     -> ready & do_wr & wr_data == captured value.
//   Each channel runs an independent IDLE/WAIT FSM. Per-channel match/fail
//   pulses are registered. Global match/fail counters saturate at all-ones.
//
// Parameters
//   NUM_CH     number of channels
//   DATA_W     captured data width per channel
//   MIN_READY  minimum ready cycles before completion (>=1)
//   MAX_READY  maximum ready cycles, 0 = unbounded
//   CNT_W      match/fail counter width
//
// Ports
//   clk         clock, all state on posedge
//   rst         asynchronous active-high reset
//   do_wr       [NUM_CH]         per-channel write request
//   ready       [NUM_CH]         per-channel ready
//   wr_data     [NUM_CH*DATA_W]  channel i at [i*DATA_W +: DATA_W]
//   busy        [NUM_CH]         attempt in progress
//   match       [NUM_CH]         one-cycle pulse, sequence completed
//   fail        [NUM_CH]         one-cycle pulse, attempt aborted
//   match_count [CNT_W]          saturating total of matches
//   fail_count  [CNT_W]          saturating total of fails
//   fail_cause  [2*NUM_CH]       only with WSC_FAIL_CAUSE_EN:
//                                01 ready dropped, 10 window timeout
//
// Optional feature macro: WSC_FAIL_CAUSE_EN

module write_seq_checker_ch #(
   parameter int DATA_W    = 8,
   parameter int MIN_READY = 1,
   parameter int MAX_READY = 0,
   parameter int RUN_W     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_do_wr,
   input  logic              i_ready,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_busy,
   output logic              o_match,
   output logic              o_fail,
   output logic              o_match_dec,
   output logic              o_fail_dec
`ifdef WSC_FAIL_CAUSE_EN
  ,output logic [1:0]        o_cause
`endif
);
   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam logic [RUN_W-1:0] MIN_R = RUN_W'(MIN_READY);
   localparam logic [RUN_W-1:0] MAX_R = RUN_W'(MAX_READY);

   state_t            r_state;
   logic [DATA_W-1:0] r_cap;
   logic [RUN_W-1:0]  r_run;
   logic              r_match;
   logic              r_fail;
   logic              w_wait;
   logic              w_drop;
   logic              w_complete;
   logic              w_timeout;
   logic [RUN_W-1:0]  w_run_inc;

   assign w_wait     = (r_state == S_WAIT);
   assign w_run_inc  = r_run + 1'b1;
   assign w_drop     = w_wait && !i_ready;
   assign w_complete = w_wait && i_ready && (r_run >= MIN_R) && i_do_wr && (i_data == r_cap);
   // Completion has priority: at run==MAX a valid completion still matches.
   assign w_timeout  = (MAX_READY != 0) && w_wait && i_ready && !w_complete && (w_run_inc > MAX_R);

   assign o_match_dec = w_complete;
   assign o_fail_dec  = w_drop | w_timeout;
   assign o_busy      = w_wait;
   assign o_match     = r_match;
   assign o_fail      = r_fail;

`ifdef WSC_FAIL_CAUSE_EN
   logic [1:0] r_cause;
   assign o_cause = r_cause;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cap   <= '0;
         r_run   <= '0;
         r_match <= 1'b0;
         r_fail  <= 1'b0;
`ifdef WSC_FAIL_CAUSE_EN
         r_cause <= 2'b00;
`endif
      end else begin
         r_match <= w_complete;
         r_fail  <= w_drop | w_timeout;
`ifdef WSC_FAIL_CAUSE_EN
         r_cause <= w_drop ? 2'b01 : (w_timeout ? 2'b10 : 2'b00);
`endif
         case (r_state)
            S_IDLE: begin
               if (i_do_wr) begin
                  r_cap   <= i_data;
                  r_run   <= '0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_drop || w_complete || w_timeout) begin
                  r_state <= S_IDLE;
               end else if (MAX_READY != 0 || r_run < MIN_R) begin
                  // Unbounded mode holds run at MIN_READY so it never wraps.
                  r_run <= w_run_inc;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

module write_seq_checker #(
   parameter int NUM_CH    = 2,
   parameter int DATA_W    = 8,
   parameter int MIN_READY = 1,
   parameter int MAX_READY = 0,
   parameter int CNT_W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        do_wr,
   input  logic [NUM_CH-1:0]        ready,
   input  logic [NUM_CH*DATA_W-1:0] wr_data,
   output logic [NUM_CH-1:0]        busy,
   output logic [NUM_CH-1:0]        match,
   output logic [NUM_CH-1:0]        fail,
   output logic [CNT_W-1:0]         match_count,
   output logic [CNT_W-1:0]         fail_count
`ifdef WSC_FAIL_CAUSE_EN
  ,output logic [2*NUM_CH-1:0]      fail_cause
`endif
);
   localparam int RUN_MAX = (MIN_READY > MAX_READY) ? MIN_READY : MAX_READY;
   localparam int RUN_W   = $clog2(RUN_MAX + 2);
   localparam int PC_W    = $clog2(NUM_CH + 1);

   if (MIN_READY < 1) begin : g_err_min
      $error("write_seq_checker: MIN_READY must be >= 1");
   end
   if (MAX_READY != 0 && MAX_READY < MIN_READY) begin : g_err_max
      $error("write_seq_checker: MAX_READY must be 0 or >= MIN_READY");
   end
   if (PC_W > CNT_W) begin : g_err_cnt
      $error("write_seq_checker: CNT_W too narrow for NUM_CH");
   end

   logic [NUM_CH-1:0] w_match_dec;
   logic [NUM_CH-1:0] w_fail_dec;
   logic [PC_W-1:0]   w_match_pc;
   logic [PC_W-1:0]   w_fail_pc;
   logic [CNT_W:0]    w_match_sum;
   logic [CNT_W:0]    w_fail_sum;
   logic [CNT_W-1:0]  r_match_count;
   logic [CNT_W-1:0]  r_fail_count;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      write_seq_checker_ch #(
         .DATA_W   (DATA_W),
         .MIN_READY(MIN_READY),
         .MAX_READY(MAX_READY),
         .RUN_W    (RUN_W)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .i_do_wr    (do_wr[g]),
         .i_ready    (ready[g]),
         .i_data     (wr_data[g*DATA_W +: DATA_W]),
         .o_busy     (busy[g]),
         .o_match    (match[g]),
         .o_fail     (fail[g]),
         .o_match_dec(w_match_dec[g]),
         .o_fail_dec (w_fail_dec[g])
`ifdef WSC_FAIL_CAUSE_EN
        ,.o_cause    (fail_cause[2*g +: 2])
`endif
      );
   end

   // Counters use this edge's decisions so they move with the pulses.
   always_comb begin
      w_match_pc = '0;
      w_fail_pc  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_match_pc = w_match_pc + PC_W'(w_match_dec[i]);
         w_fail_pc  = w_fail_pc  + PC_W'(w_fail_dec[i]);
      end
   end

   assign w_match_sum = {1'b0, r_match_count} + (CNT_W+1)'(w_match_pc);
   assign w_fail_sum  = {1'b0, r_fail_count}  + (CNT_W+1)'(w_fail_pc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_match_count <= '0;
         r_fail_count  <= '0;
      end else begin
         r_match_count <= w_match_sum[CNT_W] ? '1 : w_match_sum[CNT_W-1:0];
         r_fail_count  <= w_fail_sum[CNT_W]  ? '1 : w_fail_sum[CNT_W-1:0];
      end
   end

   assign match_count = r_match_count;
   assign fail_count  = r_fail_count;
endmodule

// File: tb/tb_write_seq_checker.sv
// Bench for write_seq_checker: DUT a uses defaults, DUT b uses MIN_READY=2,
// MAX_READY=3 and 3-bit counters so saturation is reachable quickly.
// Expected pulses are queued when the deciding stimulus is driven and
// compared by a negedge monitor when the DUT pulses.
module tb_write_seq_checker;
   typedef struct {
      int unsigned cyc;
      logic [1:0]  m;
      logic [1:0]  f;
      logic [3:0]  c;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [1:0]  a_do_wr, a_ready, a_busy, a_match, a_fail;
   logic [15:0] a_data, a_mc, a_fc;
   logic [1:0]  b_do_wr, b_ready, b_busy, b_match, b_fail;
   logic [15:0] b_data;
   logic [2:0]  b_mc, b_fc;
`ifdef WSC_FAIL_CAUSE_EN
   logic [3:0]  a_cause, b_cause;
`endif

   write_seq_checker u_dut_a (
      .clk(clk), .rst(rst), .do_wr(a_do_wr), .ready(a_ready), .wr_data(a_data),
      .busy(a_busy), .match(a_match), .fail(a_fail),
      .match_count(a_mc), .fail_count(a_fc)
`ifdef WSC_FAIL_CAUSE_EN
     ,.fail_cause(a_cause)
`endif
   );

   write_seq_checker #(.NUM_CH(2), .DATA_W(8), .MIN_READY(2), .MAX_READY(3), .CNT_W(3)) u_dut_b (
      .clk(clk), .rst(rst), .do_wr(b_do_wr), .ready(b_ready), .wr_data(b_data),
      .busy(b_busy), .match(b_match), .fail(b_fail),
      .match_count(b_mc), .fail_count(b_fc)
`ifdef WSC_FAIL_CAUSE_EN
     ,.fail_cause(b_cause)
`endif
   );

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int unsigned exp_amc = 0, exp_afc = 0, exp_bmc = 0, exp_bfc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic [1:0] w, input logic [1:0] r, input logic [15:0] d);
      a_do_wr = w; a_ready = r; a_data = d;
   endtask

   task automatic drive_b(input logic [1:0] w, input logic [1:0] r, input logic [15:0] d);
      b_do_wr = w; b_ready = r; b_data = d;
   endtask

   // off = number of edges from now until the deciding edge
   task automatic push_a(input logic [1:0] m, input logic [1:0] f, input logic [3:0] c, input int unsigned off);
      qa.push_back('{cyc + off, m, f, c});
   endtask

   task automatic push_b(input logic [1:0] m, input logic [1:0] f, input logic [3:0] c, input int unsigned off);
      qb.push_back('{cyc + off, m, f, c});
   endtask

   always @(negedge clk) begin
      if (!rst && (a_match != 2'b00 || a_fail != 2'b00)) begin
         if (qa.size() == 0) chk("a_unexpected_pulse", 32'({a_match, a_fail}), 32'd0);
         else begin
            ea = qa.pop_front();
            chk("a_pulse_cycle", cyc, ea.cyc);
            chk("a_pulse_match", 32'(a_match), 32'(ea.m));
            chk("a_pulse_fail", 32'(a_fail), 32'(ea.f));
`ifdef WSC_FAIL_CAUSE_EN
            chk("a_pulse_cause", 32'(a_cause), 32'(ea.c));
`endif
         end
      end
      if (!rst && (b_match != 2'b00 || b_fail != 2'b00)) begin
         if (qb.size() == 0) chk("b_unexpected_pulse", 32'({b_match, b_fail}), 32'd0);
         else begin
            eb = qb.pop_front();
            chk("b_pulse_cycle", cyc, eb.cyc);
            chk("b_pulse_match", 32'(b_match), 32'(eb.m));
            chk("b_pulse_fail", 32'(b_fail), 32'(eb.f));
`ifdef WSC_FAIL_CAUSE_EN
            chk("b_pulse_cause", 32'(b_cause), 32'(eb.c));
`endif
         end
      end
   end

   initial begin
      drive_a(2'b00, 2'b00, 16'h0);
      drive_b(2'b00, 2'b00, 16'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_a_busy", 32'(a_busy), 32'd0);
      chk("rst_a_match", 32'(a_match), 32'd0);
      chk("rst_a_fail", 32'(a_fail), 32'd0);
      chk("rst_a_mc", 32'(a_mc), 32'd0);
      chk("rst_a_fc", 32'(a_fc), 32'd0);
      chk("rst_b_mc", 32'(b_mc), 32'd0);
      rst = 1'b0;
      tick();

      // basic match, MIN_READY=1
      drive_a(2'b01, 2'b00, 16'h005A); tick();
      chk("t1_busy_start", 32'(a_busy), 32'd1);
      drive_a(2'b00, 2'b01, 16'h0000); tick();
      drive_a(2'b01, 2'b01, 16'h005A); push_a(2'b01, 2'b00, 4'b0000, 1); tick();
      exp_amc += 1;
      chk("t1_match", 32'(a_match), 32'd1);
      chk("t1_mc", 32'(a_mc), exp_amc);
      chk("t1_busy_end", 32'(a_busy), 32'd0);
      drive_a(2'b00, 2'b00, 16'h0000); tick();
      chk("t1_match_one_cycle", 32'(a_match), 32'd0);

      // data mismatch keeps waiting, later correct data matches
      drive_a(2'b01, 2'b00, 16'h005A); tick();
      drive_a(2'b00, 2'b01, 16'h0000); tick();
      drive_a(2'b01, 2'b01, 16'h005B); tick();
      chk("t2_no_match_bad_data", 32'(a_match), 32'd0);
      chk("t2_still_busy", 32'(a_busy), 32'd1);
      drive_a(2'b01, 2'b01, 16'h005A); push_a(2'b01, 2'b00, 4'b0000, 1); tick();
      exp_amc += 1;
      chk("t2_match", 32'(a_match), 32'd1);
      chk("t2_mc", 32'(a_mc), exp_amc);
      chk("t2_fc", 32'(a_fc), exp_afc);
      drive_a(2'b00, 2'b00, 16'h0000); tick();

      // ready drop
      drive_a(2'b01, 2'b00, 16'h0011); tick();
      drive_a(2'b00, 2'b00, 16'h0000); push_a(2'b00, 2'b01, 4'b0001, 1); tick();
      exp_afc += 1;
      chk("t3_fail", 32'(a_fail), 32'd1);
      chk("t3_fc", 32'(a_fc), exp_afc);
      tick();
      chk("t3_fail_one_cycle", 32'(a_fail), 32'd0);

      // DUT b: timeout after MAX_READY=3 ready cycles
      drive_b(2'b01, 2'b00, 16'h0000); tick();
      drive_b(2'b00, 2'b01, 16'h0000); push_b(2'b00, 2'b01, 4'b0010, 4);
      repeat (3) tick();
      chk("t4_wait_busy", 32'(b_busy), 32'd1);
      tick();
      exp_bfc += 1;
      chk("t4_timeout_fail", 32'(b_fail), 32'd1);
      chk("t4_busy_end", 32'(b_busy), 32'd0);
      chk("t4_fc", 32'(b_fc), exp_bfc);
      tick();
      chk("t4_no_restart", 32'(b_busy), 32'd0);
      drive_b(2'b00, 2'b00, 16'h0000); tick();

      // DUT b: MIN_READY=2, first completion too early
      drive_b(2'b01, 2'b00, 16'h0033); tick();
      drive_b(2'b00, 2'b01, 16'h0000); tick();
      drive_b(2'b01, 2'b01, 16'h0033); tick();
      chk("t4_early_no_match", 32'(b_match), 32'd0);
      chk("t4_early_busy", 32'(b_busy), 32'd1);
      drive_b(2'b01, 2'b01, 16'h0033); push_b(2'b01, 2'b00, 4'b0000, 1); tick();
      exp_bmc += 1;
      chk("t4_min_match", 32'(b_match), 32'd1);
      chk("t4_mc", 32'(b_mc), exp_bmc);
      drive_b(2'b00, 2'b00, 16'h0000); tick();

      // DUT b: completion exactly at the window edge wins over timeout
      drive_b(2'b01, 2'b00, 16'h00C3); tick();
      drive_b(2'b00, 2'b01, 16'h0000); repeat (3) tick();
      drive_b(2'b01, 2'b01, 16'h00C3); push_b(2'b01, 2'b00, 4'b0000, 1); tick();
      exp_bmc += 1;
      chk("t4_edge_match", 32'(b_match), 32'd1);
      chk("t4_edge_no_fail", 32'(b_fail), 32'd0);
      chk("t4_edge_mc", 32'(b_mc), exp_bmc);
      drive_b(2'b00, 2'b00, 16'h0000); tick();

      // both channels match on the same edge
      drive_a(2'b11, 2'b00, 16'h7766); tick();
      drive_a(2'b00, 2'b11, 16'h0000); tick();
      drive_a(2'b11, 2'b11, 16'h7766); push_a(2'b11, 2'b00, 4'b0000, 1); tick();
      exp_amc += 2;
      chk("t5_dual_match", 32'(a_match), 32'd3);
      chk("t5_mc", 32'(a_mc), exp_amc);
      drive_a(2'b00, 2'b00, 16'h0000); tick();

      // DUT b: dual fails drive the 3-bit fail counter into saturation
      for (int k = 0; k < 4; k++) begin
         drive_b(2'b11, 2'b00, 16'(k)); tick();
         drive_b(2'b00, 2'b00, 16'h0000); push_b(2'b00, 2'b11, 4'b0101, 1); tick();
         exp_bfc = (exp_bfc + 2 > 7) ? 7 : exp_bfc + 2;
         chk("t5_dual_fail", 32'(b_fail), 32'd3);
         chk("t5_fc_sat", 32'(b_fc), exp_bfc);
      end

      // asynchronous reset in the middle of an attempt
      drive_a(2'b01, 2'b00, 16'h0044); tick();
      drive_a(2'b00, 2'b01, 16'h0000); tick();
      chk("t6_busy_before", 32'(a_busy), 32'd1);
      #3 rst = 1'b1;
      #1;
      exp_amc = 0; exp_afc = 0; exp_bfc = 0;
      chk("t6_busy_async", 32'(a_busy), 32'd0);
      chk("t6_mc_async", 32'(a_mc), exp_amc);
      chk("t6_fc_async", 32'(a_fc), exp_afc);
      chk("t6_b_fc_async", 32'(b_fc), exp_bfc);
      #2 rst = 1'b0;
      drive_a(2'b00, 2'b01, 16'h0000); tick(); tick();
      chk("t6_idle_after_rst", 32'(a_busy), 32'd0);
      drive_a(2'b01, 2'b01, 16'h0044); tick();
      chk("t6_no_match_after_rst", 32'(a_match), 32'd0);
      chk("t6_new_start", 32'(a_busy), 32'd1);
      drive_a(2'b00, 2'b00, 16'h0000); push_a(2'b00, 2'b01, 4'b0001, 1); tick();
      exp_afc += 1;
      chk("t6_fail", 32'(a_fail), 32'd1);
      chk("t6_fc", 32'(a_fc), exp_afc);

      repeat (3) tick();
      chk("a_queue_drained", qa.size(), 32'd0);
      chk("b_queue_drained", qb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
